// File: rtl/tiny_alu_pkg.sv
// Shared definitions for the tiny ALU and its requester: opcodes, legality check,
// response status codes and requester FSM states.
package tiny_alu_pkg;

  localparam int unsigned OP_NOP = 0;
  localparam int unsigned OP_ADD = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_XOR = 3;
  localparam int unsigned OP_MUL = 4;

  localparam int unsigned TMO_CNT_BITS = 8;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ILLEGAL = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } req_state_e;

  // Opcodes above MUL are rejected locally and never reach the ALU.
  function automatic logic op_legal(input int unsigned op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/tiny_alu_requester_if.sv
// Command, response and ALU start/done signals of the tiny ALU requester.
// Signal names keep the requester's point of view (_i into it, _o out of it).
interface tiny_alu_requester_if #(
  parameter int INPUT_DATA_BITS = 8,
  parameter int OPCODE_BITS     = 3
);

  logic                         cmd_valid_i;
  logic                         cmd_ready_o;
  logic [INPUT_DATA_BITS-1:0]   cmd_a_i;
  logic [INPUT_DATA_BITS-1:0]   cmd_b_i;
  logic [OPCODE_BITS-1:0]       cmd_opcode_i;

  logic                         rsp_valid_o;
  logic                         rsp_ready_i;
  logic [2*INPUT_DATA_BITS-1:0] rsp_result_o;
  logic [1:0]                   rsp_status_o;

  logic [INPUT_DATA_BITS-1:0]   alu_a_o;
  logic [INPUT_DATA_BITS-1:0]   alu_b_o;
  logic [OPCODE_BITS-1:0]       alu_opcode_o;
  logic                         alu_start_o;
  logic [2*INPUT_DATA_BITS-1:0] alu_result_i;
  logic                         alu_done_i;

  modport requester (
    input  cmd_valid_i, cmd_a_i, cmd_b_i, cmd_opcode_i,
    input  rsp_ready_i, alu_result_i, alu_done_i,
    output cmd_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o,
    output alu_a_o, alu_b_o, alu_opcode_o, alu_start_o
  );

  modport env (
    output cmd_valid_i, cmd_a_i, cmd_b_i, cmd_opcode_i,
    output rsp_ready_i, alu_result_i, alu_done_i,
    input  cmd_ready_o, rsp_valid_o, rsp_result_o, rsp_status_o,
    input  alu_a_o, alu_b_o, alu_opcode_o, alu_start_o
  );

endinterface

// File: rtl/tiny_alu_requester.sv
// Start/done initiator for the tiny ALU with local illegal-opcode rejection.
// Define TINY_ALU_REQ_TIMEOUT_EN to build the done-timeout watchdog.
module tiny_alu_requester
  import tiny_alu_pkg::*;
#(
  parameter int INPUT_DATA_BITS = 8,
  parameter int OPCODE_BITS     = 3,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input logic                     clk_i,
  input logic                     reset_i,
  tiny_alu_requester_if.requester bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("tiny_alu_requester: TIMEOUT_CYCLES must lie in 2..255");
  end

  req_state_e                   r_state;
  logic [INPUT_DATA_BITS-1:0]   r_a;
  logic [INPUT_DATA_BITS-1:0]   r_b;
  logic [OPCODE_BITS-1:0]       r_opcode;
  logic [2*INPUT_DATA_BITS-1:0] r_result;
  status_e                      r_status;
  logic                         w_cmd_legal;

`ifdef TINY_ALU_REQ_TIMEOUT_EN
  localparam logic [TMO_CNT_BITS-1:0] TMO_LAST = TMO_CNT_BITS'(TIMEOUT_CYCLES - 1);
  logic [TMO_CNT_BITS-1:0] r_tmo_cnt;
`endif

  assign w_cmd_legal = op_legal(int'(bus.cmd_opcode_i));

  // NOTE: reset is sampled on the clock edge, and every state register uses <=
  // so all of them update together from the values seen before the edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_opcode <= '0;
      r_result <= '0;
      r_status <= ST_OK;
`ifdef TINY_ALU_REQ_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid_i) begin
            r_a      <= bus.cmd_a_i;
            r_b      <= bus.cmd_b_i;
            r_opcode <= bus.cmd_opcode_i;
            if (w_cmd_legal) begin
              r_state <= S_ISSUE;
`ifdef TINY_ALU_REQ_TIMEOUT_EN
              r_tmo_cnt <= '0;
`endif
            end else begin
              r_result <= '0;
              r_status <= ST_ILLEGAL;
              r_state  <= S_RESP;
            end
          end
        end

        // done takes priority over a timeout landing in the same cycle
        S_ISSUE: begin
          if (bus.alu_done_i) begin
            r_result <= bus.alu_result_i;
            r_status <= ST_OK;
            r_state  <= S_RESP;
          end
`ifdef TINY_ALU_REQ_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_result <= '0;
            r_status <= ST_TIMEOUT;
            r_state  <= S_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end

        S_RESP: begin
          if (bus.rsp_ready_i) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ready is masked by reset so it reads 0 while reset is held.
  assign bus.cmd_ready_o  = (r_state == S_IDLE) && !reset_i;
  assign bus.alu_start_o  = (r_state == S_ISSUE);
  assign bus.rsp_valid_o  = (r_state == S_RESP);
  assign bus.alu_a_o      = r_a;
  assign bus.alu_b_o      = r_b;
  assign bus.alu_opcode_o = r_opcode;
  assign bus.rsp_result_o = r_result;
  assign bus.rsp_status_o = r_status;

endmodule

// File: tb/tb_tiny_alu_requester.sv
// Directed bench for tiny_alu_requester with a registered-done ALU stub and a
// response scoreboard. Covers the timeout path when TINY_ALU_REQ_TIMEOUT_EN is defined.
module tb_tiny_alu_requester;
  import tiny_alu_pkg::*;

  localparam int W   = 8;
  localparam int OB  = 3;
  localparam int RW  = 2 * W;
  localparam int TMO = 16;

  typedef struct packed {
    logic [RW-1:0] result;
    logic [1:0]    status;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic stub_done_en;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  tiny_alu_requester_if #(.INPUT_DATA_BITS(W), .OPCODE_BITS(OB)) bus ();

  tiny_alu_requester #(
    .INPUT_DATA_BITS(W),
    .OPCODE_BITS    (OB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [OB-1:0] op);
    case (int'(op))
      OP_ADD:  return RW'(a) + RW'(b);
      OP_AND:  return RW'(a & b);
      OP_XOR:  return RW'(a ^ b);
      OP_MUL:  return RW'(a) * RW'(b);
      default: return '0;
    endcase
  endfunction

  // ALU stub: done is the registered start, so it also emits one trailing done.
  always @(posedge clk) begin
    if (reset) bus.alu_done_i <= 1'b0;
    else       bus.alu_done_i <= bus.alu_start_o && stub_done_en;
    bus.alu_result_i <= alu_model(bus.alu_a_o, bus.alu_b_o, bus.alu_opcode_o);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [RW-1:0] res, input status_e st);
    exp_t e;
    e.result = res;
    e.status = st;
    sb.push_back(e);
  endtask

  // Presents one command at a negedge; returns in the cycle after acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OB-1:0] op);
    check("cmd_ready_before_issue", 32'(bus.cmd_ready_o), 32'd1);
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_a_i      = a;
    bus.cmd_b_i      = b;
    bus.cmd_opcode_i = op;
    @(negedge clk);
    bus.cmd_valid_i  = 1'b0;
  endtask

  // lat counts cycles after the accepting edge; starts counts start-high cycles.
  task automatic run_to_rsp(input string tag, input int bound, output int lat, output int starts);
    lat    = 1;
    starts = 0;
    while (bus.rsp_valid_o !== 1'b1 && lat < bound) begin
      if (bus.alu_start_o === 1'b1) starts++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd1);
    check({tag, "_start_low_in_resp"}, 32'(bus.alu_start_o), 32'd0);
  endtask

  // Holds rsp_ready low for hold cycles, then completes the handshake against the scoreboard.
  task automatic finish_rsp(input string tag, input int hold);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    e = (sb.size() > 0) ? sb[0] : '0;
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.rsp_valid_o), 32'd1);
      check({tag, "_hold_result"}, 32'(bus.rsp_result_o), 32'(e.result));
      check({tag, "_hold_cmd_ready"}, 32'(bus.cmd_ready_o), 32'd0);
    end
    check({tag, "_result"}, 32'(bus.rsp_result_o), 32'(e.result));
    check({tag, "_status"}, 32'(bus.rsp_status_o), 32'(e.status));
    if (sb.size() > 0) void'(sb.pop_front());
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check({tag, "_valid_dropped"}, 32'(bus.rsp_valid_o), 32'd0);
    check({tag, "_cmd_ready_next"}, 32'(bus.cmd_ready_o), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int starts;

    reset            = 1'b1;
    stub_done_en     = 1'b1;
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_a_i      = '0;
    bus.cmd_b_i      = '0;
    bus.cmd_opcode_i = '0;
    bus.rsp_ready_i  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    check("rst_start", 32'(bus.alu_start_o), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_result", 32'(bus.rsp_result_o), 32'd0);
    check("rst_status", 32'(bus.rsp_status_o), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a_o), 32'd0);
    check("rst_alu_b", 32'(bus.alu_b_o), 32'd0);
    check("rst_alu_opcode", 32'(bus.alu_opcode_o), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);

    // ADD 3+5: start for 2 cycles, response at accept+3
    push_exp(16'h0008, ST_OK);
    issue(8'd3, 8'd5, 3'(OP_ADD));
    check("add_start", 32'(bus.alu_start_o), 32'd1);
    check("add_alu_a", 32'(bus.alu_a_o), 32'd3);
    check("add_alu_b", 32'(bus.alu_b_o), 32'd5);
    check("add_alu_opcode", 32'(bus.alu_opcode_o), 32'(OP_ADD));
    run_to_rsp("add", 40, lat, starts);
    check("add_latency", 32'(lat), 32'd3);
    check("add_start_cycles", 32'(starts), 32'd2);
    finish_rsp("add", 0);

    // MUL 0xFF*0xFF with a second command waiting during RESP
    push_exp(16'hFE01, ST_OK);
    issue(8'hFF, 8'hFF, 3'(OP_MUL));
    run_to_rsp("mul", 40, lat, starts);
    check("mul_latency", 32'(lat), 32'd3);
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_a_i      = 8'd1;
    bus.cmd_b_i      = 8'd2;
    bus.cmd_opcode_i = 3'(OP_ADD);
    finish_rsp("mul", 3);
    push_exp(16'h0003, ST_OK);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    check("queued_add_start", 32'(bus.alu_start_o), 32'd1);
    run_to_rsp("queued_add", 40, lat, starts);
    check("queued_add_latency", 32'(lat), 32'd3);
    finish_rsp("queued_add", 0);

    // Illegal opcode 6: immediate response, ALU never started
    push_exp(16'h0000, ST_ILLEGAL);
    issue(8'h12, 8'h34, 3'd6);
    run_to_rsp("illegal", 40, lat, starts);
    check("illegal_latency", 32'(lat), 32'd1);
    check("illegal_start_cycles", 32'(starts), 32'd0);
    finish_rsp("illegal", 2);
    check("illegal_start_after", 32'(bus.alu_start_o), 32'd0);

    // NOP goes through the ALU and returns 0
    push_exp(16'h0000, ST_OK);
    issue(8'd7, 8'd9, 3'(OP_NOP));
    run_to_rsp("nop", 40, lat, starts);
    check("nop_latency", 32'(lat), 32'd3);
    check("nop_start_cycles", 32'(starts), 32'd2);
    finish_rsp("nop", 0);

    // ADD 0x80+0x80 with backpressure; trailing done lands while in RESP
    push_exp(16'h0100, ST_OK);
    issue(8'h80, 8'h80, 3'(OP_ADD));
    run_to_rsp("hold", 40, lat, starts);
    finish_rsp("hold", 5);

`ifdef TINY_ALU_REQ_TIMEOUT_EN
    // ALU never answers: start held TMO cycles, then TIMEOUT
    stub_done_en = 1'b0;
    push_exp(16'h0000, ST_TIMEOUT);
    issue(8'd1, 8'd1, 3'(OP_ADD));
    run_to_rsp("timeout", 100, lat, starts);
    check("timeout_start_cycles", 32'(starts), 32'(TMO));
    check("timeout_latency", 32'(lat), 32'(TMO + 1));
    finish_rsp("timeout", 0);
    stub_done_en = 1'b1;
`else
    // Without the watchdog ISSUE waits for done however long it takes
    stub_done_en = 1'b0;
    push_exp(16'h0005, ST_OK);
    issue(8'd2, 8'd3, 3'(OP_ADD));
    repeat (40) @(negedge clk);
    check("wait_start_held", 32'(bus.alu_start_o), 32'd1);
    check("wait_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
    stub_done_en = 1'b1;
    run_to_rsp("late_done", 40, lat, starts);
    finish_rsp("late_done", 0);
`endif

    // Reset pulse during ISSUE drops the command silently
    stub_done_en = 1'b0;
    issue(8'd4, 8'd4, 3'(OP_ADD));
    check("rst_mid_start_before", 32'(bus.alu_start_o), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_start", 32'(bus.alu_start_o), 32'd0);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_mid_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    stub_done_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
    end

    // Recovery after the dropped command
    push_exp(16'h0030, ST_OK);
    issue(8'h10, 8'h20, 3'(OP_ADD));
    run_to_rsp("recover", 40, lat, starts);
    check("recover_latency", 32'(lat), 32'd3);
    finish_rsp("recover", 1);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tiny_alu_requester.md
# tiny_alu_requester

Initiator for the tiny ALU start/done command interface. It accepts operations from an upstream valid/ready command stream and drives `a`/`b`/`opcode`/`start` to the ALU. It waits for `done`, then returns the 16-bit result with a status code on a valid/ready response stream. The block sits between a test or processor front end and the ALU. It adds local rejection of illegal opcodes and an optional done-timeout watchdog.

## Interface
- `INPUT_DATA_BITS`, default 8: operand width; result width is 2×.
- `OPCODE_BITS`, default 3: opcode width.
- `TIMEOUT_CYCLES`, default 16: maximum cycles in ISSUE before a timeout is declared. Legal range is 2..255.

Reset is synchronous and active-high on `reset_i`; one clock, `clk_i`.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous active-high reset.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: requester can accept a command.
- `cmd_a_i` in `INPUT_DATA_BITS`: operand A.
- `cmd_b_i` in `INPUT_DATA_BITS`: operand B.
- `cmd_opcode_i` in `OPCODE_BITS`: operation.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: downstream accepts the response.
- `rsp_result_o` out 2×`INPUT_DATA_BITS`: ALU result.
- `rsp_status_o` out 2: status; 0 OK, 1 ILLEGAL, 2 TIMEOUT.
- `alu_a_o` out `INPUT_DATA_BITS`: operand A to the ALU.
- `alu_b_o` out `INPUT_DATA_BITS`: operand B to the ALU.
- `alu_opcode_o` out `OPCODE_BITS`: opcode to the ALU.
- `alu_start_o` out 1: start request to the ALU.
- `alu_result_i` in 2×`INPUT_DATA_BITS`: result from the ALU.
- `alu_done_i` in 1: completion from the ALU.

## Operation
- **Legal opcodes:** NOP=0, ADD=1, AND=2, XOR=3, MUL=4. Values 5..7 are illegal.
- **States:**
  - IDLE: `cmd_ready_o`=1.
  - ISSUE: `alu_start_o`=1; operands and opcode held stable from registers.
  - RESP: `rsp_valid_o`=1.
- **IDLE:**
  - When `cmd_valid_i` && `cmd_ready_o`, register the operands and opcode.
  - Legal opcode: go to ISSUE.
  - Illegal opcode: go to RESP with status ILLEGAL and result 0. `alu_start_o` is never asserted.
- **ISSUE:**
  - `alu_done_i`=1: capture `alu_result_i`, set status OK, go to RESP.
  - Done and timeout in the same cycle: done wins.
  - NOP is issued normally; the ALU returns result 0.
- **RESP:**
  - Result and status stay stable until `rsp_ready_i`=1, then go to IDLE.
  - `cmd_ready_o`=0 throughout RESP, so at most one operation is outstanding.
- **Spurious done:** `alu_done_i` is ignored outside ISSUE. The ALU produces one trailing done after `start` drops, and this must be ignored.
- **Reset values:**
  - State IDLE; `cmd_ready_o`=0 during reset, 1 on the first cycle after reset.
  - `alu_start_o`=0, `rsp_valid_o`=0.
  - `rsp_result_o`=0, `rsp_status_o`=0.
  - `alu_a_o`/`alu_b_o`/`alu_opcode_o`=0.
- **Reset mid-operation:** the in-flight command is dropped with no response. `alu_start_o` is low on the cycle after reset is sampled.

## Timing
- **Legal command accepted at edge N:**
  - `alu_start_o` high in cycle N+1.
  - The ALU registers done, so `alu_done_i` is high in N+2.
  - `rsp_valid_o` high and `alu_start_o` low in N+3.
- **Illegal opcode:** `rsp_valid_o` high in N+1.
- **Throughput:** a response accepted in cycle M gives `cmd_ready_o`=1 in M+1. A new legal op therefore costs at least 4 cycles.
- **Timeout counter:**
  - 8-bit, cleared on entering ISSUE, incremented each ISSUE cycle.
  - Timeout fires when the count equals `TIMEOUT_CYCLES`-1 without done.
  - `alu_start_o` is high for exactly `TIMEOUT_CYCLES` cycles, then RESP with status TIMEOUT and result 0.

## Configuration
- Macro: `TINY_ALU_REQ_TIMEOUT_EN`.
- **Defined:** the timeout counter and TIMEOUT status are active as described above.
- **Undefined:**
  - The counter is not built; ISSUE waits indefinitely for `alu_done_i`.
  - `rsp_status_o` never takes value 2.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `tiny_alu_pkg`:
  - opcode constants and an opcode-legal function;
  - status enum (OK/ILLEGAL/TIMEOUT);
  - requester state enum (IDLE/ISSUE/RESP).
- The ALU also imports this package for its opcode constants.
- Single module. The timeout watchdog is small enough to stay inline under the macro; no sub-module.

## Test plan
- ADD a=3, b=5 → `rsp_result_o`=0x0008, status 0, `rsp_valid_o` at accept+3. Exactly one `alu_start_o` pulse of 2 cycles.
- MUL a=0xFF, b=0xFF → result 0xFE01, status 0. A second command issued while in RESP is not accepted until the response handshake completes.
- Opcode 6 → status 1, result 0, `rsp_valid_o` at accept+1. `alu_start_o` stays 0 throughout.
- ALU stub never asserts done, `TIMEOUT_CYCLES`=16, macro defined → start high for 16 cycles, then status 2, result 0.
- `rsp_ready_i` held low 5 cycles after ADD 0x80+0x80 → result 0x0100 held stable all 5 cycles, `cmd_ready_o`=0, trailing ALU done ignored.
- `reset_i` pulsed one cycle during ISSUE → next cycle `alu_start_o`=0, `rsp_valid_o`=0, `cmd_ready_o`=1; no response emitted.
